// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and a
// constant-width helper used to size the bit counter.
package serial_adder_pkg;

  // Controller states; the unused code 2'd3 is steered back to idle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders and an OR gate.
// Purely combinational; the serial adder uses exactly one instance.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (.a(a),  .b(b),    .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(c_in), .s(s),  .c(c2));

  assign c_out = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
// added LSB first through a single full adder, and the registered result
// (sum, carry out, signed overflow) is held until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             OVF
);

  // One extra bit so the count can represent WIDTH without wrapping.
  localparam int CNT_W = clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c_in (cy),
    .s    (fa_s),
    .c_out(fa_c)
  );

  // State register; synchronous reset forces idle.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake decode from the registered state.
  // NOTE: defaults are assigned first so no path leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, LSB-first shifting, carry feedback and bit count.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh <= A;
            b_sh <= B;
            cy   <= C_in;
            cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          r_sh <= {fa_s, r_sh[WIDTH-1:1]};
          cy   <= fa_c;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers load only on the edge that enters DONE; on that edge
  // cy still holds the carry into the MSB, giving overflow directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      S     <= '0;
      C_out <= 1'b0;
      OVF   <= 1'b0;
    end else if (state == ST_SHIFT && last_bit) begin
      S     <= {fa_s, r_sh[WIDTH-1:1]};
      C_out <= fa_c;
      OVF   <= cy ^ fa_c;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors on an 8-bit
// instance, start-ignore and mid-operation reset cases, then a random
// sweep on both 8-bit and 16-bit instances against an integer model.
module tb_serial_adder;

  logic        clk;
  logic        reset;

  logic        start8,  busy8,  done8,  cin8,  cout8,  ovf8;
  logic [7:0]  a8, b8, s8;
  logic        start16, busy16, done16, cin16, cout16, ovf16;
  logic [15:0] a16, b16, s16;

  int n_tests;
  int n_fail;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .C_in(cin8),
    .busy(busy8), .done(done8), .S(s8), .C_out(cout8), .OVF(ovf8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16), .C_in(cin16),
    .busy(busy16), .done(done16), .S(s16), .C_out(cout16), .OVF(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one addition on the selected instance and checks timing and result.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input string tag);
    logic [16:0] sum;
    logic [15:0] exp_s;
    logic        exp_c;
    logic        exp_ovf;
    int          busy_cnt;
    int          lat;
    logic        seen;
    if (w == 8) begin
      sum     = {9'd0, a[7:0]} + {9'd0, b[7:0]} + {16'd0, cin};
      exp_s   = {8'd0, sum[7:0]};
      exp_c   = sum[8];
      exp_ovf = (a[7] == b[7]) && (sum[7] != a[7]);
      a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; start8 = 1'b1;
    end else begin
      sum     = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      exp_s   = sum[15:0];
      exp_c   = sum[16];
      exp_ovf = (a[15] == b[15]) && (sum[15] != a[15]);
      a16 = a; b16 = b; cin16 = cin; start16 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    // Scramble inputs after acceptance; result must not depend on them.
    a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16;
    busy_cnt = (w == 8) ? int'(busy8) : int'(busy16);
    lat  = 1;
    seen = 1'b0;
    for (int i = 2; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if ((w == 8) ? done8 : done16) begin
        seen = 1'b1;
        lat  = i;
      end else if ((w == 8) ? busy8 : busy16) begin
        busy_cnt++;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"},   32'(lat), 32'(w + 1));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(w));
    check({tag, " busy_at_done"}, 32'((w == 8) ? busy8 : busy16), 32'd0);
    check({tag, " S"},     32'((w == 8) ? {8'd0, s8} : s16), 32'(exp_s));
    check({tag, " C_out"}, 32'((w == 8) ? cout8 : cout16), 32'(exp_c));
    check({tag, " OVF"},   32'((w == 8) ? ovf8 : ovf16), 32'(exp_ovf));
    @(negedge clk);
    check({tag, " done_1cyc"}, 32'((w == 8) ? done8 : done16), 32'd0);
    check({tag, " S_hold"}, 32'((w == 8) ? {8'd0, s8} : s16), 32'(exp_s));
  endtask

  initial begin
    int done_cnt;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy8), 32'd0);
    check("rst done", 32'(done8), 32'd0);
    check("rst S",    32'(s8),    32'd0);
    check("rst C_out", 32'(cout8), 32'd0);
    check("rst OVF",  32'(ovf8),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed expectations.
    run_op(8, 16'h005A, 16'h003C, 1'b0, "d5a_3c");   // S=96 C=0 OVF=1
    check("d5a_3c S_const", 32'(s8), 32'h96);
    check("d5a_3c OVF_const", 32'(ovf8), 32'd1);
    run_op(8, 16'h00FF, 16'h0001, 1'b0, "dff_01");   // S=00 C=1 OVF=0
    check("dff_01 C_const", 32'(cout8), 32'd1);
    run_op(8, 16'h0000, 16'h0000, 1'b1, "d00_cin");  // S=01 C=0 OVF=0
    check("d00_cin S_const", 32'(s8), 32'h01);
    run_op(8, 16'h0080, 16'h0080, 1'b0, "d80_80");   // S=00 C=1 OVF=1
    check("d80_80 OVF_const", 32'(ovf8), 32'd1);
    run_op(8, 16'h007F, 16'h0000, 1'b1, "d7f_cin");  // S=80 C=0 OVF=1
    check("d7f_cin S_const", 32'(s8), 32'h80);

    // Start during SHIFT must be ignored: one done, S = 0x30.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    done_cnt = 0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (done8) done_cnt++;
      @(negedge clk);
    end
    check("ign done_pulses", 32'(done_cnt), 32'd1);
    check("ign S", 32'(s8), 32'h30);
    check("ign C_out", 32'(cout8), 32'd0);

    // Reset during the 4th SHIFT cycle aborts with outputs cleared.
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy_before", 32'(busy8), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(busy8), 32'd0);
    check("abort S", 32'(s8), 32'd0);
    check("abort C_out", 32'(cout8), 32'd0);
    check("abort OVF", 32'(ovf8), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) done_cnt++;
      @(negedge clk);
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    run_op(8, 16'h0013, 16'h0022, 1'b1, "after_abort");  // S=36
    check("after_abort S_const", 32'(s8), 32'h36);

    // Random sweep on both widths.
    for (int i = 0; i < 1000; i++) begin
      run_op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), "rnd8");
    end
    for (int i = 0; i < 1000; i++) begin
      run_op(16, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), "rnd16");
    end
    run_op(16, 16'h7FFF, 16'h0001, 1'b0, "d16_ovf");
    check("d16_ovf S_const", 32'(s16), 32'h8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
